mips_multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Consumes Opcode and the funct field (Immediate[5:0]) produced by the fetch stage.
- Drives the fetch stage's IorD select and the PC, memory, IR, register-file and ALU control strobes.
- Stretches memory states with a mem_ready handshake so that slow memories can insert wait states.

---
 rtl/mips_ctrl_pkg.sv | 64 ++++++
 rtl/mips_ctrl_decode.sv | 70 +++++++
 rtl/mips_multicycle_ctrl.sv | 125 ++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// mux selects and the packed strobe bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_EXEC     = 4'd6,
    ST_RTYPE_WB = 4'd7,
    ST_BEQ      = 4'd8,
    ST_JUMP     = 4'd9,
    ST_ADDI_EX  = 4'd10,
    ST_ADDI_WB  = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_TRAP   = 2'd3;

  localparam logic [1:0] ALUB_REG     = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SL2 = 2'd3;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  // States that wait on the memory handshake.
  function automatic logic is_wait_state(state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// State -> strobe table, purely combinational; mem_done only qualifies the
// FETCH-cycle IR/PC loads.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_done,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.ir_write  = mem_done;
        ctrl.pc_write  = mem_done;
      end
      ST_DECODE: ctrl.alu_src_b = ALUB_IMM_SL2;
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
      end
      ST_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ST_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
      end
      ST_ADDI_WB: ctrl.reg_write = 1'b1;
      ST_TRAP: begin
        ctrl.illegal   = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_TRAP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main multicycle MIPS control FSM; Moore strobes, FETCH/MEMRD/MEMWR stretch on mem_ready=0.
// Define MIPS_CTRL_PERF_EN to add the instr_cnt/stall_cnt performance counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int          CNTW    = 32,
  parameter logic [15:0] ILL_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic        mem_ready,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic [1:0]  PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        illegal,
  output logic [15:0] trap_pc,
  output logic [3:0]  state_o
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [CNTW-1:0] instr_cnt,
  output logic [CNTW-1:0] stall_cnt
`endif
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_ok;
  logic   unused_funct;

  // Funct goes straight to the ALU decode; the FSM has no use for it.
  assign unused_funct = ^Funct;

  // Holding reset masks the handshake so no FETCH write strobe leaks out.
  assign mem_ok = mem_ready & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = mem_ok ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BEQ;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EX;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEMADR:  state_d = (Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:   state_d = mem_ok ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:   state_d = mem_ok ? ST_FETCH : ST_MEMWR;
      ST_EXEC:    state_d = ST_RTYPE_WB;
      ST_ADDI_EX: state_d = ST_ADDI_WB;
      default:    state_d = ST_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state    (state_q),
    .mem_done (mem_ok),
    .ctrl     (ctrl)
  );

  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign illegal     = ctrl.illegal;
  assign trap_pc     = ILL_VEC;
  assign state_o     = state_q;

`ifdef MIPS_CTRL_PERF_EN
  logic [CNTW-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            instr_inc, stall_inc;

  always_comb begin
    instr_inc   = (state_q != ST_FETCH) && (state_d == ST_FETCH);
    stall_inc   = is_wait_state(state_q) && !mem_ready;
    instr_cnt_d = instr_cnt_q + CNTW'(instr_inc);
    stall_cnt_d = stall_cnt_q + CNTW'(stall_inc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction phase paths with random wait states.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam logic [15:0] VEC = 16'hBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_ready;
  logic [5:0]  Opcode, Funct;
  logic        IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic        ALUSrcA, RegDst, RegWrite, MemtoReg, illegal;
  logic [15:0] trap_pc;
  logic [3:0]  state_o;
  logic [15:0] instr_cnt, stall_cnt;

  mips_multicycle_ctrl #(.CNTW(16), .ILL_VEC(VEC)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .illegal(illegal),
    .trap_pc(trap_pc), .state_o(state_o)
`ifdef MIPS_CTRL_PERF_EN
    , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
  );

`ifndef MIPS_CTRL_PERF_EN
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif

  logic [16:0] obs;
  assign obs = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource,
                ALUSrcA, ALUSrcB, ALUOp, RegDst, RegWrite, MemtoReg, illegal};

  int vectors = 0;
  int miscompares = 0;
  int instr_m = 0;
  int stall_m = 0;
  state_e path[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // What each phase of an instruction asserts; anything not listed is 0.
  function automatic logic [16:0] exp_out(state_e ph, logic mr);
    logic iord = 0, mrd = 0, mwr = 0, irw = 0, pcw = 0, pcc = 0, asa = 0;
    logic rdst = 0, rw = 0, m2r = 0, ill = 0;
    logic [1:0] pcs = 0, asb = 0, aop = 0;
    case (ph)
      ST_FETCH:    begin mrd = 1; asb = 1; irw = mr; pcw = mr; end
      ST_DECODE:   asb = 3;
      ST_MEMADR:   begin asa = 1; asb = 2; end
      ST_MEMRD:    begin iord = 1; mrd = 1; end
      ST_MEMWB:    begin rw = 1; m2r = 1; end
      ST_MEMWR:    begin iord = 1; mwr = 1; end
      ST_EXEC:     begin asa = 1; aop = 2; end
      ST_RTYPE_WB: begin rw = 1; rdst = 1; end
      ST_BEQ:      begin asa = 1; aop = 1; pcc = 1; pcs = 1; end
      ST_JUMP:     begin pcw = 1; pcs = 2; end
      ST_ADDI_EX:  begin asa = 1; asb = 2; end
      ST_ADDI_WB:  rw = 1;
      ST_TRAP:     begin ill = 1; pcw = 1; pcs = 3; end
      default:     ;
    endcase
    return {iord, mrd, mwr, irw, pcw, pcc, pcs, asa, asb, aop, rdst, rw, m2r, ill};
  endfunction

  function automatic int latency(logic [5:0] op);
    case (op)
      OP_LW:                    return 5;
      OP_SW, OP_RTYPE, OP_ADDI: return 4;
      default:                  return 3;
    endcase
  endfunction

  task automatic build_path(input logic [5:0] op);
    path = '{ST_FETCH, ST_DECODE};
    case (op)
      OP_LW:    begin path.push_back(ST_MEMADR); path.push_back(ST_MEMRD); path.push_back(ST_MEMWB); end
      OP_SW:    begin path.push_back(ST_MEMADR); path.push_back(ST_MEMWR); end
      OP_RTYPE: begin path.push_back(ST_EXEC); path.push_back(ST_RTYPE_WB); end
      OP_ADDI:  begin path.push_back(ST_ADDI_EX); path.push_back(ST_ADDI_WB); end
      OP_BEQ:   path.push_back(ST_BEQ);
      OP_J:     path.push_back(ST_JUMP);
      default:  path.push_back(ST_TRAP);
    endcase
  endtask

  task automatic step(input state_e ph, input logic mr);
    @(posedge clk);
    #1;
    mem_ready = mr;
    Funct = 6'($urandom);
    #3;
    check($sformatf("state@%s", ph.name()), 32'(state_o), 32'(ph));
    check($sformatf("ctrl@%s", ph.name()), 32'(obs), 32'(exp_out(ph, mr)));
  endtask

  // fw/mw: exact wait cycles in FETCH / memory phase, or -1 for random.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    int idx = 0, waits = 0, want;
    logic mr;
    state_e ph;
    build_path(op);
    Opcode = op;
    while (idx < path.size()) begin
      ph = path[idx];
      if (is_wait_state(ph)) begin
        want = (ph == ST_FETCH) ? fw : mw;
        if (want >= 0) mr = (waits >= want);
        else           mr = (waits >= 3) || ($urandom_range(99) < 70);
      end else begin
        mr = 1'($urandom_range(1));
      end
      step(ph, mr);
      if (is_wait_state(ph) && !mr) begin
        waits++;
        stall_m++;
      end else begin
        idx++;
        waits = 0;
      end
    end
    instr_m++;
  endtask

  task automatic measure(input logic [5:0] op);
    int n = 0;
    bit seen = 0;
    Opcode = op;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      #1 mem_ready = 1'b1;
      #3;
      if (k > 1 && state_o == 4'(ST_FETCH)) begin
        seen = 1;
        n = k - 1;
        mem_ready = 1'b0;
        stall_m++;
      end
    end
    instr_m++;
    check($sformatf("latency_op%02h", op), 32'(n), 32'(latency(op)));
  endtask

  task automatic check_perf();
    @(posedge clk);
    #1;
`ifdef MIPS_CTRL_PERF_EN
    check("instr_cnt", 32'(instr_cnt), 32'(16'(instr_m)));
    check("stall_cnt", 32'(stall_cnt), 32'(16'(stall_m)));
`endif
    mem_ready = 1'b0;
    stall_m++;
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_RTYPE;
    ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_ADDI;

    rst = 1'b0; mem_ready = 1'b1; Opcode = OP_LW; Funct = '0;
    #7;
    check("reset_state", 32'(state_o), 32'(ST_FETCH));
    check("reset_ctrl", 32'(obs), 32'(exp_out(ST_FETCH, 1'b0)));
    check("trap_pc", 32'(trap_pc), 32'(VEC));
`ifdef MIPS_CTRL_PERF_EN
    check("reset_instr_cnt", 32'(instr_cnt), 0);
    check("reset_stall_cnt", 32'(stall_cnt), 0);
`endif
    mem_ready = 1'b0;
    #1 rst = 1'b1;
    stall_m = 1;

    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 3);
    check_perf();
    run_instr(OP_BEQ, 0, 0);
    run_instr(6'h3F, 0, 0);
    run_instr(OP_RTYPE, 2, 0);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_J, 1, 0);
    check_perf();

    for (int i = 0; i < 6; i++) measure(ops[i]);
    measure(6'h3F);
    check_perf();

    // Reset while MEMRD is stretched by a slow memory.
    Opcode = OP_LW;
    step(ST_FETCH, 1'b1);
    step(ST_DECODE, 1'b1);
    step(ST_MEMADR, 1'b1);
    step(ST_MEMRD, 1'b0);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("midwait_rst_state", 32'(state_o), 32'(ST_FETCH));
    check("midwait_rst_ctrl", 32'(obs), 32'(exp_out(ST_FETCH, 1'b0)));
    @(posedge clk);
    #1;
    check("held_rst_state", 32'(state_o), 32'(ST_FETCH));
    check("held_rst_ctrl", 32'(obs), 32'(exp_out(ST_FETCH, 1'b0)));
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    instr_m = 0;
    stall_m = 0;
`ifdef MIPS_CTRL_PERF_EN
    check("rst_instr_cnt", 32'(instr_cnt), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
    stall_m = 1;

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(6) == 6) ? 6'($urandom_range(63)) : ops[$urandom_range(5)];
      run_instr(op, -1, -1);
      if (i % 25 == 24) check_perf();
    end
    check_perf();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
